vedic_pp_combiner: RTL and testbench
====================================

# vedic_pp_combiner

Pipelined partial-product combiner for the 16x16 Vedic multiplier. It takes the four 16-bit partial products from the 8x8 Vedic units and produces the 32-bit product over two register stages. Its internal carry-propagate adders replace the flat combinational adder tree. It sits between the 8x8 multiplier array (upstream) and the product consumer (downstream), with a valid/ready handshake on both sides.

## Interface
Parameters:
- PP_W, default 16: width of each partial product. Only 16 is supported.
- CNT_W, default 16: width of the completed-product counter.

Ports:
- clk  in  1  rising-edge clock, the only clock in the block.
- rst  in  1  reset, asynchronous and active-high.
- in_valid  in  1  partial-product set on q0..q3 is valid.
- in_ready  out  1  block accepts the set this cycle.
- q0  in  PP_W  a[7:0]*b[7:0]
- q1  in  PP_W  a[15:8]*b[7:0]
- q2  in  PP_W  a[7:0]*b[15:8]
- q3  in  PP_W  a[15:8]*b[15:8]
- out_valid  out  1  p holds a valid product.
- out_ready  in  1  downstream accepts p this cycle.
- p  out  32  product.
- done_cnt  out  CNT_W  number of products handed off; saturates at all-ones.

## Operation
- Transfer rules:
  - An input transfer happens when in_valid && in_ready.
  - An output transfer happens when out_valid && out_ready.
- Stage 1 registers:
  - s1_sum = q1 + q2, 17-bit, carry kept.
  - s1_q0 = q0.
  - s1_q3 = q3.
  - s1_valid.
- Stage 2 computes:
  - t = s1_sum + {9'b0, s1_q0[15:8]}, 17-bit, cannot overflow.
  - p[7:0] = s1_q0[7:0].
  - p[15:8] = t[7:0].
  - p[31:16] = s1_q3 + {7'b0, t[16:8]}, 16-bit, truncation-free for valid 8x8 products.
  - Stage 2 registers p and s2_valid. out_valid is s2_valid.
- Advance rules:
  - adv2 = s1_valid && (!s2_valid || out_ready).
  - in_ready = !s1_valid || adv2. This is combinational from out_ready; no other combinational in-to-out path exists.
- Register updates:
  - When adv2: stage 2 loads and s2_valid becomes 1.
  - Else if an output transfer occurs: s2_valid becomes 0.
  - On an input transfer: stage 1 loads and s1_valid becomes 1.
  - Else if adv2: s1_valid becomes 0.
- done_cnt increments by 1 on each output transfer and holds at 2^CNT_W-1.
- Data registers keep their values while their stage is stalled. Bubbles do not change p.

## Timing
- Reset values (asynchronous, immediate):
  - s1_valid = s2_valid = 0, so out_valid = 0.
  - p = 0.
  - done_cnt = 0.
  - Stage-1 data = 0.
  - in_ready goes to 1 as soon as reset deasserts.
- Latency: a set accepted at edge N gives out_valid=1 after edge N+1, when out_ready is held high.
- Throughput: one product per cycle with out_ready high. No bubble is inserted between back-to-back sets.
- Stall: with out_ready=0 and both stages full, in_ready=0. p, out_valid and the stage-1 contents hold.
- Simultaneous events:
  - When full, an output transfer and an input transfer in the same cycle are both honoured. Nothing is lost or duplicated.
- Reset mid-operation: in-flight sets are discarded and done_cnt clears. No product is emitted after reset.
- out_valid never drops without an output transfer. p is stable while out_valid && !out_ready.

## Structure
- A shared package vedic_pkg holds:
  - PP_W=16 and PROD_W=32
  - the product type
  - the shift constant HALF=8
- The upstream 8x8 units and the 12-bit adder use the same package.
- One sub-module, vedic_pipe_reg: a valid/ready register slice parameterised on data width. It is instantiated twice, and the combinational adds sit between the instances.

## Test plan
- Reset then idle: out_valid=0, p=0, done_cnt=0 and in_ready=1 throughout.
- Single set: q0=q1=q2=q3=16'hFE01 (0xFFFF*0xFFFF), out_ready=1. Required: p=32'hFFFE0001 two edges after acceptance, done_cnt=1.
- Mixed set: q0=16'h0068, q1=16'h0024, q2=0, q3=0 (0x1234*0x0002). Required: p=32'h00002468.
- Backpressure: stream 4 sets with out_ready=0. Required: 2 sets accepted, in_ready=0 afterwards. After releasing out_ready, the products appear in order with none lost and done_cnt=4.
- Random streaming: 1000 random a,b, with partials computed by the bench and random in_valid/out_ready. Required: p==a*b in order, and done_cnt equals the number of output transfers.
- Async reset: assert rst with both stages full. Required: out_valid drops immediately with no clock edge, and no stale product appears after reset.

Source files
------------

// File: rtl/vedic_pkg.sv
// vedic_pkg: shared types and constants for the 16x16 Vedic multiplier.
// Used by the 8x8 Vedic units, the 12-bit adder and the partial-product
// combiner.
//   PP_W      width of one 8x8 partial product
//   PROD_W    width of the full 16x16 product
//   HALF      shift between adjacent partial-product columns
//   product_t full product type
//   s1_data_t contents of the first combiner register stage
//   combine() finishes the product from the stage-1 contents
package vedic_pkg;

  localparam int PP_W   = 16;
  localparam int PROD_W = 32;
  localparam int HALF   = 8;

  typedef logic [PROD_W-1:0] product_t;

  typedef struct packed {
    logic [PP_W-1:0] q3;   // a_hi * b_hi
    logic [PP_W-1:0] q0;   // a_lo * b_lo
    logic [PP_W:0]   sum;  // q1 + q2 with the carry kept
  } s1_data_t;

  // The low byte of q0 passes straight through. Its high byte is added to
  // the middle column. That column's carry-out and upper bits then go into q3.
  function automatic product_t combine(input s1_data_t s);
    logic [PP_W:0]   t;
    logic [PP_W-1:0] hi;
    t  = s.sum + {{(PP_W + 1 - HALF){1'b0}}, s.q0[PP_W-1:HALF]};
    hi = s.q3 + {{(PP_W - HALF - 1){1'b0}}, t[PP_W:HALF]};
    return {hi, t[HALF-1:0], s.q0[HALF-1:0]};
  endfunction

endpackage

// File: rtl/vedic_pipe_reg.sv
// vedic_pipe_reg: a valid/ready register slice with a full-throughput
// pass-through ready. It accepts new data whenever it is empty or its
// content leaves in the same cycle.
//   clk, rst              clock, asynchronous active-high reset
//   in_valid/in_ready     upstream handshake
//   in_data               W-bit payload to capture
//   out_valid/out_ready   downstream handshake
//   out_data              registered payload (holds while stalled)
module vedic_pipe_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         valid;
  logic [W-1:0] data;

  assign in_ready  = !valid || out_ready;
  assign out_valid = valid;
  assign out_data  = data;

  // Slice state: load on an input transfer, otherwise empty on an output transfer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= {W{1'b0}};
    end else if (in_valid && in_ready) begin
      valid <= 1'b1;
      data  <= in_data;
    end else if (valid && out_ready) begin
      valid <= 1'b0;
    end else begin
      valid <= valid;
    end
  end

endmodule

// File: rtl/vedic_pp_combiner.sv
// vedic_pp_combiner: two-stage pipelined combiner for the four 8x8 partial
// products of a 16x16 Vedic multiply.
//   clk, rst              clock, asynchronous active-high reset
//   in_valid/in_ready     partial-product set handshake
//   q0..q3                partial products (lo*lo, hi*lo, lo*hi, hi*hi)
//   out_valid/out_ready   product handshake
//   p                     32-bit registered product
//   done_cnt              saturating count of products handed off
module vedic_pp_combiner
  import vedic_pkg::*;
#(
  parameter int PP_W  = 16,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [PP_W-1:0]  q0,
  input  logic [PP_W-1:0]  q1,
  input  logic [PP_W-1:0]  q2,
  input  logic [PP_W-1:0]  q3,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      p,
  output logic [CNT_W-1:0] done_cnt
);

  s1_data_t s1_in;
  s1_data_t s1_data;
  logic     s1_valid;
  logic     s2_ready;
  product_t s2_in;

  // The two middle partial products share a column. Their sum is taken
  // before the first register so that stage 2 has only two short adds.
  always_comb begin
    s1_in     = '0;
    s1_in.q3  = q3;
    s1_in.q0  = q0;
    s1_in.sum = {1'b0, q1} + {1'b0, q2};
  end

  vedic_pipe_reg #(.W($bits(s1_data_t))) u_stage1 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (s1_in),
    .out_valid (s1_valid),
    .out_ready (s2_ready),
    .out_data  (s1_data)
  );

  assign s2_in = combine(s1_data);

  vedic_pipe_reg #(.W(32)) u_stage2 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (s1_valid),
    .in_ready  (s2_ready),
    .in_data   (s2_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (p)
  );

  // Handoff counter: counts output transfers and sticks at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done_cnt <= {CNT_W{1'b0}};
    end else if (out_valid && out_ready && (done_cnt != {CNT_W{1'b1}})) begin
      done_cnt <= done_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      done_cnt <= done_cnt;
    end
  end

endmodule

// File: tb/tb_vedic_pp_combiner.sv
module tb_vedic_pp_combiner;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] q0, q1, q2, q3;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] p;
  logic [15:0] done_cnt;

  vedic_pp_combiner #(.PP_W(16), .CNT_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .q0        (q0),
    .q1        (q1),
    .q2        (q2),
    .q3        (q3),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .p         (p),
    .done_cnt  (done_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] cur_exp;
  int          n_out = 0;
  int          n_acc = 0;
  logic        accepted;
  logic        hold_prev = 1'b0;
  logic [31:0] hold_p = 32'h0;

  task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge with inputs already set; samples just before
  // the rising edge, then returns at the next falling edge.
  task automatic tick();
    #4;
    accepted = 1'b0;
    if (hold_prev) begin
      check_value("stall_valid_hold", {63'd0, out_valid}, 64'd1);
      check_value("stall_p_hold", {32'd0, p}, {32'd0, hold_p});
    end
    hold_prev = out_valid && !out_ready;
    hold_p    = p;
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check_value("spurious_output", {32'd0, p}, 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        check_value("product", {32'd0, p}, {32'd0, exp_q.pop_front()});
      end
      n_out++;
    end
    if (in_valid && in_ready) begin
      exp_q.push_back(cur_exp);
      n_acc++;
      accepted = 1'b1;
    end
    @(negedge clk);
  endtask

  task automatic set_ab(input logic [15:0] a, input logic [15:0] b);
    q0 = {8'h00, a[7:0]}  * {8'h00, b[7:0]};
    q1 = {8'h00, a[15:8]} * {8'h00, b[7:0]};
    q2 = {8'h00, a[7:0]}  * {8'h00, b[15:8]};
    q3 = {8'h00, a[15:8]} * {8'h00, b[15:8]};
    cur_exp = {16'h0000, a} * {16'h0000, b};
  endtask

  // Hold in_valid until the current set is accepted, with a cycle budget.
  task automatic offer(input bit rand_ready);
    int budget;
    budget = 0;
    accepted = 1'b0;
    while (!accepted && budget < 200) begin
      in_valid = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (rand_ready) out_ready = ($urandom_range(0, 2) != 0);
      tick();
      budget++;
    end
    if (!accepted) check_value("accept_timeout", 64'd0, 64'd1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int budget;
    budget = 0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while (exp_q.size() != 0 && budget < 50) begin
      tick();
      budget++;
    end
    check_value("drain_empty", exp_q.size(), 64'd0);
  endtask

  initial begin
    int base;
    int acc_base;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    q0 = 16'h0; q1 = 16'h0; q2 = 16'h0; q3 = 16'h0; cur_exp = 32'h0;

    // Reset state
    #2;
    check_value("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check_value("rst_p", {32'd0, p}, 64'd0);
    check_value("rst_done_cnt", {48'd0, done_cnt}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_value("rst_in_ready", {63'd0, in_ready}, 64'd1);
    @(negedge clk);

    // Idle
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_value("idle_out_valid", {63'd0, out_valid}, 64'd0);
      check_value("idle_in_ready", {63'd0, in_ready}, 64'd1);
    end
    check_value("idle_p", {32'd0, p}, 64'd0);

    // Single all-ones set: latency of two edges
    q0 = 16'hFE01; q1 = 16'hFE01; q2 = 16'hFE01; q3 = 16'hFE01;
    cur_exp = 32'hFFFE0001;
    in_valid = 1'b1;
    tick();
    check_value("single_accept", {63'd0, accepted}, 64'd1);
    in_valid = 1'b0;
    check_value("single_not_yet", {63'd0, out_valid}, 64'd0);
    tick();
    check_value("single_valid", {63'd0, out_valid}, 64'd1);
    check_value("single_p", {32'd0, p}, 64'hFFFE0001);
    tick();
    check_value("single_done_cnt", {48'd0, done_cnt}, 64'd1);

    // Mixed set 0x1234 * 0x0002
    q0 = 16'h0068; q1 = 16'h0024; q2 = 16'h0000; q3 = 16'h0000;
    cur_exp = 32'h00002468;
    offer(1'b0);
    drain();
    check_value("mixed_done_cnt", {48'd0, done_cnt}, 64'd2);

    // Backpressure: four sets offered with out_ready low
    base = n_out;
    acc_base = n_acc;
    out_ready = 1'b0;
    in_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      set_ab(16'h1111 * (k + 1), 16'h0101 + k);
      if (k < 2) tick();
    end
    // sets 2 and 3 were loaded into the drive but only set index 1.. are pending
    tick();
    tick();
    check_value("bp_accepted", n_acc - acc_base, 64'd2);
    check_value("bp_in_ready", {63'd0, in_ready}, 64'd0);
    check_value("bp_out_valid", {63'd0, out_valid}, 64'd1);
    out_ready = 1'b1;
    offer(1'b0);
    set_ab(16'hBEEF, 16'h00FF);
    offer(1'b0);
    drain();
    check_value("bp_out_count", n_out - base, 64'd4);
    check_value("bp_done_cnt", {48'd0, done_cnt}, 64'd6);

    // Random streaming
    for (int i = 0; i < 1000; i++) begin
      set_ab($urandom_range(0, 65535), $urandom_range(0, 65535));
      offer(1'b1);
    end
    drain();
    tick();
    check_value("rand_done_cnt", {48'd0, done_cnt}, n_out);

    // Async reset with both stages full
    out_ready = 1'b0;
    set_ab(16'h0F0F, 16'h7777);
    in_valid = 1'b1;
    tick();
    set_ab(16'hA5A5, 16'h5A5A);
    tick();
    in_valid = 1'b0;
    check_value("full_out_valid", {63'd0, out_valid}, 64'd1);
    check_value("full_in_ready", {63'd0, in_ready}, 64'd0);
    #1;
    rst = 1'b1;
    #1;
    check_value("async_out_valid", {63'd0, out_valid}, 64'd0);
    check_value("async_done_cnt", {48'd0, done_cnt}, 64'd0);
    check_value("async_p", {32'd0, p}, 64'd0);
    exp_q.delete();
    hold_prev = 1'b0;
    n_out = 0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_value("post_rst_out_valid", {63'd0, out_valid}, 64'd0);
    end
    check_value("post_rst_outputs", n_out, 64'd0);
    check_value("post_rst_done_cnt", {48'd0, done_cnt}, 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
